// File: rtl/rv32_pkg.sv
// Shared RV32I core types used by the pipeline control blocks.
package rv32_pkg;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } WBSel_t;

endpackage

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing for the 5-stage RV32I core: load-use bubbles, taken-branch
// flushes, data-memory wait freezes with a timeout watchdog, and a stall-cycle counter.
module hazard_stall_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned LU_BUBBLES  = 2,
  parameter int unsigned MEM_TIMEOUT = 256,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_ID,
  input  logic [31:0]      inst_EX,
  input  logic             RegWEn_EX,
  input  WBSel_t           WBSel_EX,
  input  logic             br_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_MEM_WB,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned        WcntW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0]         LuInit   = 2'(LU_BUBBLES - 1);
  localparam logic [WcntW-1:0]   WcntLast = WcntW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StRun, StLuStall, StDmemWait, StErr} state_e;

  state_e           state_q, state_d;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q;

  logic [6:0] opc_id;
  logic [4:0] rd_ex, rs1_id, rs2_id;
  logic       uses_rs1, uses_rs2, load_use, mstall;

  assign opc_id = inst_ID[6:0];
  assign rs1_id = inst_ID[19:15];
  assign rs2_id = inst_ID[24:20];
  assign rd_ex  = inst_EX[11:7];

  // Only opcode/register fields matter here; the rest is consumed elsewhere.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_ID[31:25], inst_ID[14:7], inst_EX[31:12], inst_EX[6:0]};

  always_comb begin
    uses_rs1 = !(opc_id inside {OpLui, OpAuipc, OpJal});
    uses_rs2 = opc_id inside {OpReg, OpStore, OpBranch};
  end

  assign load_use = RegWEn_EX && (WBSel_EX == WB_MEM) && (rd_ex != 5'd0) &&
                    ((uses_rs1 && (rd_ex == rs1_id)) || (uses_rs2 && (rd_ex == rs2_id)));
  assign mstall   = dmem_req_MEM && !dmem_ready;

  always_comb begin
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    wcnt_d       = '0;
    mem_err_d    = mem_err_q;
    pc_en        = 1'b1;
    en_IF_ID     = 1'b1;
    en_ID_EX     = 1'b1;
    en_EX_MEM    = 1'b1;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_MEM_WB = 1'b0;

    if (state_q == StErr) begin
      pc_en     = 1'b0;
      en_IF_ID  = 1'b0;
      en_ID_EX  = 1'b0;
      en_EX_MEM = 1'b0;
      wcnt_d    = wcnt_q;
    end else if (mstall) begin
      // Freeze everything up to MEM; WB gets a bubble. lu_cnt is kept for resumption.
      pc_en        = 1'b0;
      en_IF_ID     = 1'b0;
      en_ID_EX     = 1'b0;
      en_EX_MEM    = 1'b0;
      flush_MEM_WB = 1'b1;
      if (wcnt_q == WcntLast) begin
        state_d   = StErr;
        mem_err_d = 1'b1;
        wcnt_d    = wcnt_q;
      end else begin
        state_d = StDmemWait;
        wcnt_d  = wcnt_q + 1'b1;
      end
    end else if (br_taken_EX) begin
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
      lu_cnt_d    = '0;
      state_d     = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_use) begin
            pc_en       = 1'b0;
            en_IF_ID    = 1'b0;
            flush_ID_EX = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_d  = StLuStall;
              lu_cnt_d = LuInit;
            end
          end
        end
        StLuStall: begin
          pc_en       = 1'b0;
          en_IF_ID    = 1'b0;
          flush_ID_EX = 1'b1;
          lu_cnt_d    = lu_cnt_q - 2'd1;
          if (lu_cnt_q == 2'd1) state_d = StRun;
        end
        StDmemWait: state_d = (lu_cnt_q != 2'd0) ? StLuStall : StRun;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      lu_cnt_q  <= '0;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      lu_cnt_q  <= lu_cnt_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
      if (!pc_en && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized plus directed bench for hazard_stall_ctrl against a cycle-level reference model;
// a second instance with a 4-bit counter exercises saturation.
module tb_hazard_stall_ctrl;
  import rv32_pkg::*;

  localparam int unsigned LuBubbles  = 2;
  localparam int unsigned MemTimeout = 256;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] inst_id, inst_ex;
  logic        regwen_ex, br_taken, dmem_req, dmem_ready;
  WBSel_t      wbsel_ex;

  logic        pc_en, en_if_id, en_id_ex, en_ex_mem, fl_if_id, fl_id_ex, fl_mem_wb, mem_err;
  logic [31:0] stall_cycles;
  logic        n4_pc_en, n4_en_if_id, n4_en_id_ex, n4_en_ex_mem;
  logic        n4_fl_if_id, n4_fl_id_ex, n4_fl_mem_wb, n4_mem_err;
  logic [3:0]  n4_stall;

  hazard_stall_ctrl #(.LU_BUBBLES(LuBubbles), .MEM_TIMEOUT(MemTimeout), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .inst_ID(inst_id), .inst_EX(inst_ex), .RegWEn_EX(regwen_ex),
    .WBSel_EX(wbsel_ex), .br_taken_EX(br_taken), .dmem_req_MEM(dmem_req),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .en_IF_ID(en_if_id), .en_ID_EX(en_id_ex),
    .en_EX_MEM(en_ex_mem), .flush_IF_ID(fl_if_id), .flush_ID_EX(fl_id_ex),
    .flush_MEM_WB(fl_mem_wb), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  hazard_stall_ctrl #(.LU_BUBBLES(LuBubbles), .MEM_TIMEOUT(MemTimeout), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .inst_ID(inst_id), .inst_EX(inst_ex), .RegWEn_EX(regwen_ex),
    .WBSel_EX(wbsel_ex), .br_taken_EX(br_taken), .dmem_req_MEM(dmem_req),
    .dmem_ready(dmem_ready), .pc_en(n4_pc_en), .en_IF_ID(n4_en_if_id),
    .en_ID_EX(n4_en_id_ex), .en_EX_MEM(n4_en_ex_mem), .flush_IF_ID(n4_fl_if_id),
    .flush_ID_EX(n4_fl_id_ex), .flush_MEM_WB(n4_fl_mem_wb), .mem_err(n4_mem_err),
    .stall_cycles(n4_stall)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: pending bubbles, whether a memory wait is in progress, its length so far.
  bit          m_err;
  int unsigned m_bubbles, m_wait_len, m_stalls;
  bit          m_waiting;

  logic [6:0] ctrl;
  assign ctrl = {pc_en, en_if_id, en_id_ex, en_ex_mem, fl_if_id, fl_id_ex, fl_mem_wb};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_err = 1'b0; m_bubbles = 0; m_wait_len = 0; m_stalls = 0; m_waiting = 1'b0;
  endtask

  function automatic bit ref_load_use(input logic [31:0] id, input logic [31:0] ex,
                                      input logic we, input WBSel_t ws);
    logic [6:0] op;
    logic [4:0] rd;
    bit         r1, r2;
    op = id[6:0];
    rd = ex[11:7];
    r1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
    r2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return we && (ws == WB_MEM) && (rd != 5'd0) &&
           ((r1 && rd == id[19:15]) || (r2 && rd == id[24:20]));
  endfunction

  function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] i_lui(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [9];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 8)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  // One clock: drive, check at the falling edge, then advance the model past the rising edge.
  task automatic step(input logic [31:0] id, input logic [31:0] ex, input logic we,
                      input WBSel_t ws, input logic br, input logic rq, input logic rdy);
    bit         lu, ms;
    logic [6:0] e_ctrl;
    inst_id = id; inst_ex = ex; regwen_ex = we; wbsel_ex = ws;
    br_taken = br; dmem_req = rq; dmem_ready = rdy;
    lu = ref_load_use(id, ex, we, ws);
    ms = rq && !rdy;
    if (m_err)                                    e_ctrl = 7'b0000_000;
    else if (ms)                                  e_ctrl = 7'b0000_001;
    else if (br)                                  e_ctrl = 7'b1111_110;
    else if (!m_waiting && (m_bubbles > 0 || lu)) e_ctrl = 7'b0011_010;
    else                                          e_ctrl = 7'b1111_000;
    @(negedge clk);
    check("ctrl", 32'(ctrl), 32'(e_ctrl));
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("stall_cycles", stall_cycles, m_stalls);
    check("stall_sat4", 32'(n4_stall), (m_stalls > 15) ? 32'd15 : m_stalls);
    @(posedge clk);
    #1;
    if (!e_ctrl[6]) m_stalls++;
    if (m_err) begin
    end else if (ms) begin
      if (m_wait_len == MemTimeout - 1) m_err = 1'b1;
      else begin
        m_wait_len++;
        m_waiting = 1'b1;
      end
    end else begin
      m_wait_len = 0;
      if (br) begin
        m_bubbles = 0;
        m_waiting = 1'b0;
      end else if (m_waiting) m_waiting = 1'b0;
      else if (m_bubbles > 0) m_bubbles--;
      else if (lu) m_bubbles = LuBubbles - 1;
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) step(Nop, Nop, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] add_x6, lw_x5;
    int unsigned base;
    add_x6 = i_add(5'd6, 5'd5, 5'd2);
    lw_x5  = i_lw(5'd5, 5'd1);

    rst_n = 1'b0;
    inst_id = Nop; inst_ex = Nop; regwen_ex = 1'b0; wbsel_ex = WB_ALU;
    br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
    model_reset();
    #3;
    check("reset_ctrl", 32'(ctrl), 32'h78);
    check("reset_mem_err", 32'(mem_err), 32'd0);
    check("reset_stall", stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use: exactly two bubbles.
    step(add_x6, lw_x5, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b1);
    step(add_x6, Nop, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("lu_two_bubbles", stall_cycles, 32'd2);

    // No-hazard cases, then a store consuming rs2.
    step(i_lui(5'd5), lw_x5, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b1);
    step(i_add(5'd6, 5'd0, 5'd0), i_lw(5'd0, 5'd1), 1'b1, WB_MEM, 1'b0, 1'b0, 1'b1);
    check("no_stall_cases", stall_cycles, 32'd2);
    step(i_sw(5'd5, 5'd7), lw_x5, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("store_rs2_stall", stall_cycles, 32'd4);

    // Taken branch beats load-use.
    step(add_x6, lw_x5, 1'b1, WB_MEM, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("branch_no_stall", stall_cycles, 32'd4);

    // Memory wait interrupting the second load-use bubble.
    base = m_stalls;
    step(add_x6, lw_x5, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(add_x6, Nop, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b0);
    step(add_x6, Nop, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b1);
    idle(3);
    check("lu_mstall_total", stall_cycles - 32'(base), 32'd5);

    for (int i = 0; i < 3000; i++) begin
      step(rand_inst(), rand_inst(), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) != 0) ? WB_MEM : WB_ALU,
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    // Watchdog: 256 cycles of waiting, then frozen in the error state.
    idle(3);
    for (int i = 0; i < MemTimeout; i++) step(Nop, Nop, 1'b0, WB_ALU, 1'b0, 1'b1, 1'b0);
    step(Nop, Nop, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b1);
    check("timeout_mem_err", 32'(mem_err), 32'd1);
    check("timeout_frozen", 32'(ctrl), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(rand_inst(), rand_inst(), 1'b1, WB_MEM, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    check("stall_saturated", 32'(n4_stall), 32'd15);

    // Asynchronous reset mid-cycle while frozen.
    inst_id = Nop; inst_ex = Nop; regwen_ex = 1'b0; br_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_err", 32'(mem_err), 32'd0);
    check("async_rst_ctrl", 32'(ctrl), 32'h78);
    check("async_rst_stall", stall_cycles, 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(add_x6, lw_x5, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      step(rand_inst(), rand_inst(), 1'($urandom_range(0, 1)), WB_MEM,
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
